// File: rtl/sysid_probe_master.sv
// Avalon-MM read master that fetches the system ID word (address 0) and the
// build timestamp word (address 1), compares each against build-time
// constants, and reports pass / fail / timeout to the fabric.
module sysid_probe_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1498255003,
  parameter int          TIMEOUT_CYCLES     = 1024,
  parameter int          TIMER_W            = 11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timed_out,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    IDLE,
    CMD_ID,
    RSP_ID,
    CMD_TS,
    RSP_TS,
    FINISH
  } state_t;

  // Last timer value a transaction may use before it is abandoned.
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_t             state;
  state_t             state_next;
  logic [TIMER_W-1:0] timer;
  logic               timer_expired;
  logic               capture_id;
  logic               capture_ts;
  logic               timeout_hit;
  logic               clear_flags;
  logic               in_phase;
  logic               entering_cmd;

  assign timer_expired = (timer == TIMER_LAST);
  assign in_phase      = (state == CMD_ID) || (state == RSP_ID) ||
                         (state == CMD_TS) || (state == RSP_TS);
  assign entering_cmd  = ((state_next == CMD_ID) || (state_next == CMD_TS)) &&
                         (state_next != state);

  // State register; reset returns to IDLE immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; a response seen in the timeout cycle takes priority.
  always_comb begin
    state_next  = state;
    capture_id  = 1'b0;
    capture_ts  = 1'b0;
    timeout_hit = 1'b0;
    clear_flags = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next  = CMD_ID;
          clear_flags = 1'b1;
        end
      end
      CMD_ID: begin
        if (!avm_waitrequest && avm_readdatavalid) begin
          capture_id = 1'b1;
          state_next = CMD_TS;
        end else if (timer_expired) begin
          timeout_hit = 1'b1;
          state_next  = FINISH;
        end else if (!avm_waitrequest) begin
          state_next = RSP_ID;
        end
      end
      RSP_ID: begin
        if (avm_readdatavalid) begin
          capture_id = 1'b1;
          state_next = CMD_TS;
        end else if (timer_expired) begin
          timeout_hit = 1'b1;
          state_next  = FINISH;
        end
      end
      CMD_TS: begin
        if (!avm_waitrequest && avm_readdatavalid) begin
          capture_ts = 1'b1;
          state_next = FINISH;
        end else if (timer_expired) begin
          timeout_hit = 1'b1;
          state_next  = FINISH;
        end else if (!avm_waitrequest) begin
          state_next = RSP_TS;
        end
      end
      RSP_TS: begin
        if (avm_readdatavalid) begin
          capture_ts = 1'b1;
          state_next = FINISH;
        end else if (timer_expired) begin
          timeout_hit = 1'b1;
          state_next  = FINISH;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Per-transaction timer: restarts on each new command, counts while a read is open.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (entering_cmd) begin
      timer <= '0;
    end else if (in_phase) begin
      timer <= timer + 1'b1;
    end else begin
      timer <= '0;
    end
  end

  // Bus and status outputs are registered from the upcoming state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      avm_read    <= (state_next == CMD_ID) || (state_next == CMD_TS);
      avm_address <= (state_next == CMD_TS) || (state_next == RSP_TS);
      busy        <= (state_next == CMD_ID) || (state_next == RSP_ID) ||
                     (state_next == CMD_TS) || (state_next == RSP_TS);
      done        <= (state_next == FINISH);
    end
  end

  // Result capture; values persist until overwritten, flags clear on each start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_ok     <= 1'b0;
      ts_ok     <= 1'b0;
      timed_out <= 1'b0;
      id_value  <= '0;
      ts_value  <= '0;
    end else begin
      if (clear_flags) begin
        id_ok     <= 1'b0;
        ts_ok     <= 1'b0;
        timed_out <= 1'b0;
      end
      if (capture_id) begin
        id_value <= avm_readdata;
        id_ok    <= (avm_readdata == EXPECTED_ID);
      end
      if (capture_ts) begin
        ts_value <= avm_readdata;
        ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
      end
      if (timeout_hit) begin
        timed_out <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sysid_probe_master.md
Name: sysid_probe_master

Overview:
- Avalon-MM read master that queries the system ID peripheral: reads ID word (address 0) then timestamp word (address 1).
- Compares both against build-time expected values and reports a pass/fail/timeout status.
- Sits in the FPGA fabric beside the HPS bridge, so fabric logic can confirm the loaded SoC image matches the RTL build without software involvement.

Parameters:
- EXPECTED_ID, 32'h0000_0000, expected word at address 0
- EXPECTED_TIMESTAMP, 32'd1498255003, expected word at address 1
- TIMEOUT_CYCLES, 1024, max cycles per read transaction (command plus response) before abort; >=2
- TIMER_W, 11, counter width; must satisfy 2^TIMER_W > TIMEOUT_CYCLES

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins probe sequence when idle
- avm_address  out  1  word address: 0 = ID, 1 = timestamp
- avm_read  out  1  read command
- avm_waitrequest  in  1  slave stall; command held while high
- avm_readdata  in  32  response data
- avm_readdatavalid  in  1  response qualifier
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end (pass, fail or timeout)
- id_ok  out  1  captured ID == EXPECTED_ID
- ts_ok  out  1  captured timestamp == EXPECTED_TIMESTAMP
- timed_out  out  1  last sequence aborted on timeout
- id_value  out  32  captured ID word
- ts_value  out  32  captured timestamp word

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE. All outputs 0: avm_read, avm_address, busy, done, id_ok, ts_ok, timed_out, id_value, ts_value. Timer 0.
- All outputs are registered.
- States: IDLE, CMD_ID, RSP_ID, CMD_TS, RSP_TS, FINISH.
- IDLE:
  - start=1 -> CMD_ID; busy=1.
  - id_ok, ts_ok, timed_out cleared on that same edge; id_value/ts_value retain old values until overwritten.
  - start while busy is ignored; no queuing.
- CMD_ID:
  - avm_read=1, avm_address=0, held stable while avm_waitrequest=1.
  - The first cycle of avm_read=1 occurs the cycle after start is sampled.
  - Command accepted in the cycle avm_read=1 and avm_waitrequest=0; next cycle avm_read=0 -> RSP_ID.
- RSP_ID:
  - On avm_readdatavalid=1: id_value <= avm_readdata; id_ok <= (avm_readdata==EXPECTED_ID); -> CMD_TS.
  - readdatavalid in the same cycle as acceptance is legal (zero-latency slave) and must be captured. Acceptance cycle and readdatavalid both high -> skip RSP_ID, go straight to CMD_TS.
- CMD_TS / RSP_TS: identical to CMD_ID / RSP_ID with avm_address=1, capturing ts_value/ts_ok; then -> FINISH.
- FINISH: done=1 for exactly one cycle, busy=0 in the same cycle -> IDLE. Results held until next start.
- readdatavalid outside RSP_x, or outside an acceptance cycle, is ignored.
- Timeout:
  - Timer clears on entering each CMD_x state and increments every cycle in CMD_x/RSP_x.
  - If timer reaches TIMEOUT_CYCLES-1 without completing the current response: avm_read <= 0, timed_out <= 1, ok flag for the current and any remaining words stays 0 -> FINISH.
  - Response arriving in the same cycle as the timeout hit wins: it is captured and no timeout occurs.
- Late responses after a timeout abort are ignored in IDLE.
- Reset mid-sequence: immediate return to IDLE, avm_read drops asynchronously, no done pulse.

Test Plan:
- Zero-wait, 1-cycle-latency slave returning 0 / 1498255003; start pulse -> two reads (addr 0 then 1), done pulse, id_ok=1, ts_ok=1, timed_out=0, ts_value=1498255003.
- waitrequest held high 5 cycles on each command -> avm_read and avm_address stable throughout, each read issued exactly once, same pass result.
- Slave returns 32'h1234_5678 for timestamp -> ts_ok=0, id_ok=1, ts_value=32'h1234_5678, done pulses once.
- Slave never asserts readdatavalid for address 1 -> done exactly TIMEOUT_CYCLES cycles after entering CMD_TS; timed_out=1, ts_ok=0, id_ok=1, avm_read=0 afterwards.
- Zero-latency slave (readdatavalid in the acceptance cycle) plus start re-pulsed while busy -> both words captured correctly, second start ignored, exactly one done.
- Reset asserted during RSP_ID -> all outputs 0 immediately; after release, a new start completes a full pass sequence.
